egress_arbiter: RTL and testbench

- Per-output-port arbiter placed directly downstream of the ingress filters. One instance serves each egress port.
- Collects the filtered streams (axis_d_source_t) from NUM_INGRESS ingress filters. Selects the frames whose tdest equals PORT_ID.
- Grants one input at a time, round-robin, locked for a whole frame until tlast. Forwards beats through a registered skid buffer to the egress MAC side.

---
 rtl/filter_defs.sv | 21 ++
 rtl/egress_arbiter_if.sv | 28 ++
 rtl/axis_skid_buffer.sv | 52 +++++
 rtl/egress_arbiter.sv | 162 ++++++++++++++++
 tb/tb_egress_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_defs.sv
// Shared definitions for the packet filter datapath:
// stream typedefs, arbiter state and sizing constants.
package filter_defs;

    localparam int NUM_PORTS = 4;
    localparam int DEFAULT_STALL_LIMIT = 255;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic [1:0]  tdest;
        logic        tlast;
    } axis_d_source_t;

    typedef struct packed {
        logic tready;
    } axis_d_sink_t;

endpackage

// File: rtl/egress_arbiter_if.sv
// Stream bundle between the ingress filters, one egress arbiter
// and its egress MAC side.
interface egress_arbiter_if
    import filter_defs::*;
#(
    parameter int NUM_INGRESS = NUM_PORTS
);

    axis_d_source_t [NUM_INGRESS-1:0] in_source;
    axis_d_sink_t   [NUM_INGRESS-1:0] in_sink;
    axis_d_source_t                   out_source;
    axis_d_sink_t                     out_sink;

    modport master (
        output in_source,
        input  in_sink,
        input  out_source,
        output out_sink
    );

    modport slave (
        input  in_source,
        output in_sink,
        output out_source,
        input  out_sink
    );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready buffer with a registered output stage;
// in_ready depends only on internal state.
module axis_skid_buffer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             sp_valid;
    logic [WIDTH-1:0] sp_data;
    logic             push;
    logic             pop;

    assign in_ready = !sp_valid;
    assign push     = in_valid && !sp_valid;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sp_valid  <= 1'b0;
            sp_data   <= '0;
        end else if (pop) begin
            // a full buffer never pushes, so the spare drains first
            if (sp_valid) begin
                out_data <= sp_data;
                sp_valid <= 1'b0;
            end else if (push) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                sp_valid <= 1'b1;
                sp_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// Round-robin, frame-locked arbiter for one egress port.
// Define EGRESS_ARB_STATS_EN to add frames_fwd/stall_events counters.
module egress_arbiter
    import filter_defs::*;
#(
    parameter int         NUM_INGRESS     = NUM_PORTS,
    parameter logic [1:0] PORT_ID         = 2'd0,
    parameter int         STALL_LIMIT     = DEFAULT_STALL_LIMIT,
    parameter int         STALL_CTR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    egress_arbiter_if.slave                bus,
    output logic [$clog2(NUM_INGRESS)-1:0] grant_idx,
    output logic                           busy,
    output logic                           stall_timeout
`ifdef EGRESS_ARB_STATS_EN
    ,
    output logic [15:0]                    frames_fwd,
    output logic [15:0]                    stall_events
`endif
);

    localparam int GW  = $clog2(NUM_INGRESS);
    localparam int SCW = STALL_CTR_WIDTH;
    localparam logic [SCW-1:0] LIM    = SCW'(STALL_LIMIT);
    localparam logic [SCW-1:0] LIM_M1 = SCW'(STALL_LIMIT - 1);

    arb_state_t             state;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          pick;
    logic [GW-1:0]          idx;
    logic                   found;
    logic [NUM_INGRESS-1:0] req;
    logic [SCW-1:0]         stall_ctr;
    logic                   g_tvalid;
    logic                   g_tlast;
    logic                   sk_in_valid;
    logic                   sk_in_ready;
    logic                   xfer;
    logic                   sk_out_valid;
    logic [16:0]            sk_out_data;

    always_comb begin
        for (int i = 0; i < NUM_INGRESS; i++) begin
            req[i] = bus.in_source[i].tvalid
                  && bus.in_source[i].tdest == PORT_ID;
        end
    end

    // first requester after last_grant, wrapping
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_INGRESS; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_INGRESS);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign g_tvalid    = bus.in_source[grant_idx].tvalid;
    assign g_tlast     = bus.in_source[grant_idx].tlast;
    assign sk_in_valid = state == BUSY && g_tvalid;
    assign xfer        = sk_in_valid && sk_in_ready;

    always_comb begin
        bus.in_sink = '0;
        if (state == BUSY) begin
            bus.in_sink[grant_idx].tready = sk_in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            grant_idx     <= '0;
            last_grant    <= GW'(NUM_INGRESS - 1);
            stall_ctr     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && |req) begin
                        grant_idx <= pick;
                        state     <= BUSY;
                        busy      <= 1'b1;
                        stall_ctr <= '0;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        stall_ctr <= '0;
                        if (g_tlast) begin
                            last_grant    <= grant_idx;
                            state         <= IDLE;
                            busy          <= 1'b0;
                            stall_timeout <= 1'b0;
                        end
                    end else if (!g_tvalid) begin
                        // backpressure alone never reaches here
                        if (stall_ctr != LIM) begin
                            stall_ctr <= stall_ctr + SCW'(1);
                        end
                        if (stall_ctr >= LIM_M1) begin
                            stall_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .WIDTH(17)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (sk_in_valid),
        .in_ready (sk_in_ready),
        .in_data  ({bus.in_source[grant_idx].tdata, g_tlast}),
        .out_valid(sk_out_valid),
        .out_ready(bus.out_sink.tready),
        .out_data (sk_out_data)
    );

    always_comb begin
        bus.out_source        = '0;
        bus.out_source.tvalid = sk_out_valid;
        bus.out_source.tdata  = sk_out_data[16:1];
        bus.out_source.tlast  = sk_out_data[0];
        bus.out_source.tdest  = PORT_ID;
    end

`ifdef EGRESS_ARB_STATS_EN
    logic stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frames_fwd   <= '0;
            stall_events <= '0;
            stall_q      <= 1'b0;
        end else begin
            stall_q <= stall_timeout;
            if (sk_out_valid && bus.out_sink.tready && sk_out_data[0]
                && frames_fwd != 16'hFFFF) begin
                frames_fwd <= frames_fwd + 16'd1;
            end
            if (stall_timeout && !stall_q && stall_events != 16'hFFFF) begin
                stall_events <= stall_events + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_egress_arbiter.sv
// Directed scoreboard bench for egress_arbiter: fairness, filtering,
// backpressure, starvation, enable and mid-frame reset.
module tb_egress_arbiter;
    import filter_defs::*;

    localparam int NI = 4;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  dest;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [1:0] grant_idx;
    logic       busy;
    logic       stall_timeout;
`ifdef EGRESS_ARB_STATS_EN
    logic [15:0] frames_fwd;
    logic [15:0] stall_events;
`endif

    egress_arbiter_if #(.NUM_INGRESS(NI)) bus ();

    egress_arbiter #(
        .NUM_INGRESS    (NI),
        .PORT_ID        (2'd0),
        .STALL_LIMIT    (4),
        .STALL_CTR_WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .bus          (bus),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .stall_timeout(stall_timeout)
`ifdef EGRESS_ARB_STATS_EN
        ,
        .frames_fwd   (frames_fwd),
        .stall_events (stall_events)
`endif
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    mon_en = 1'b1;
    bit    bp_mode = 1'b0;
    beat_t src_q[NI][$];
    exp_t  exp_q[$];
    bit    held_v = 1'b0;
    exp_t  held;
    int    first_out_cyc = -1;
    int    start_cyc = 0;
    int    out_cnt = 0;
    bit    st_track = 1'b0;
    int    st_low = 0;
    int    st_rise = -1;
    bit    stall_seen = 1'b0;
    bit    t0_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int i, input logic [15:0] base,
                             input logic [15:0] inc, input int n,
                             input logic [1:0] dest, input int gbeat,
                             input int glen);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d    = base + inc * 16'(k);
            b.dest = dest;
            b.last = (k == n - 1);
            b.gap  = (k == gbeat) ? glen : 0;
            src_q[i].push_back(b);
        end
    endtask

    task automatic exp_frame(input logic [15:0] base,
                             input logic [15:0] inc, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d    = base + inc * 16'(k);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive();
        axis_d_source_t s;
        beat_t          b;
        for (int i = 0; i < NI; i++) begin
            s = '0;
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                if (b.gap > 0) begin
                    b.gap--;
                    src_q[i][0] = b;
                end else begin
                    s.tvalid = 1'b1;
                    s.tdata  = b.d;
                    s.tdest  = b.dest;
                    s.tlast  = b.last;
                end
            end
            bus.in_source[i] = s;
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (held_v) begin
            chk("hold_valid", 32'(bus.out_source.tvalid), 32'd1);
            chk("hold_data",
                32'({bus.out_source.tdata, bus.out_source.tlast}),
                32'(held));
        end
        if (bus.out_source.tvalid && bus.out_sink.tready) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(bus.out_source.tdata), 32'(e.d));
                chk("beat_last", 32'(bus.out_source.tlast), 32'(e.last));
                chk("beat_tdest", 32'(bus.out_source.tdest), 32'd0);
            end
        end
        held_v = bus.out_source.tvalid && !bus.out_sink.tready;
        held   = {bus.out_source.tdata, bus.out_source.tlast};
        if (stall_timeout) stall_seen = 1'b1;
        if (bus.in_sink[0].tready) t0_seen = 1'b1;
        if (st_track) begin
            if (stall_timeout && st_rise < 0) st_rise = st_low;
            if (busy && !bus.in_source[1].tvalid) st_low++;
        end
    endtask

    task automatic step();
        bit took[NI];
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            took[i] = bus.in_source[i].tvalid && bus.in_sink[i].tready;
        end
        if (mon_en) monitor();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (took[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (bp_mode) bus.out_sink.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        else bus.out_sink.tready = 1'b1;
        drive();
    endtask

    task automatic run_until(input string tag, input int max);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < max) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(n < max), 32'd1);
        step();
        step();
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_granted"}, 32'(busy), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_stall"}, 32'(stall_timeout), 32'd0);
        chk({tag, "_in_sink"}, 32'(bus.in_sink), 32'd0);
        chk({tag, "_out"}, 32'(bus.out_source), 32'd0);
    endtask

    initial begin
        int n;
        bus.in_source = '0;
        bus.out_sink.tready = 1'b1;
        reset = 1'b1;
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b0;

        // fairness: 0,2,3 request back to back
        for (int f = 0; f < 2; f++) begin
            add_frame(0, 16'h0000 + 16'(f) * 16'h10, 16'd1, 2, 2'd0, -1, 0);
            add_frame(2, 16'h2000 + 16'(f) * 16'h10, 16'd1, 2, 2'd0, -1, 0);
            add_frame(3, 16'h3000 + 16'(f) * 16'h10, 16'd1, 2, 2'd0, -1, 0);
        end
        for (int f = 0; f < 2; f++) begin
            exp_frame(16'h0000 + 16'(f) * 16'h10, 16'd1, 2);
            exp_frame(16'h2000 + 16'(f) * 16'h10, 16'd1, 2);
            exp_frame(16'h3000 + 16'(f) * 16'h10, 16'd1, 2);
        end
        drive();
        run_until("fair", 200);

        // single frame with latency
        add_frame(1, 16'h1111, 16'h1111, 4, 2'd0, -1, 0);
        exp_frame(16'h1111, 16'h1111, 4);
        first_out_cyc = -1;
        drive();
        start_cyc = cyc;
        wait_busy("single");
        chk("single_grant", 32'(grant_idx), 32'd1);
        run_until("single", 100);
        chk("single_latency", 32'(first_out_cyc - start_cyc), 32'd2);

        // filtering on tdest
        t0_seen = 1'b0;
        add_frame(0, 16'h0A00, 16'd1, 3, 2'd1, -1, 0);
        add_frame(1, 16'h1A00, 16'd1, 3, 2'd0, -1, 0);
        exp_frame(16'h1A00, 16'd1, 3);
        drive();
        run_until("filter", 100);
        chk("filter_grant", 32'(grant_idx), 32'd1);
        chk("filter_t0_ready", 32'(t0_seen), 32'd0);
        chk("filter_in0_kept", 32'(src_q[0].size()), 32'd3);
        src_q[0].delete();
        drive();

        // backpressure 1,0,0,1
        stall_seen = 1'b0;
        bp_mode = 1'b1;
        add_frame(2, 16'h2B00, 16'd1, 6, 2'd0, -1, 0);
        exp_frame(16'h2B00, 16'd1, 6);
        drive();
        run_until("bp", 200);
        bp_mode = 1'b0;
        chk("bp_no_stall", 32'(stall_seen), 32'd0);

        // starvation mid-frame
        st_low = 0;
        st_rise = -1;
        st_track = 1'b1;
        add_frame(1, 16'h5100, 16'd1, 4, 2'd0, 2, 5);
        exp_frame(16'h5100, 16'd1, 4);
        drive();
        run_until("starve", 100);
        st_track = 1'b0;
        chk("starve_rise_cycle", 32'(st_rise), 32'd4);
        chk("starve_low_cycles", 32'(st_low), 32'd5);
        chk("starve_cleared", 32'(stall_timeout), 32'd0);

        // enable low holds off new grants
        en = 1'b0;
        add_frame(1, 16'h6100, 16'd1, 2, 2'd0, -1, 0);
        exp_frame(16'h6100, 16'd1, 2);
        drive();
        repeat (4) step();
        chk("en_low_busy", 32'(busy), 32'd0);
        chk("en_low_pending", 32'(src_q[1].size()), 32'd2);
        en = 1'b1;
        run_until("en", 100);

        // leave last_grant at 0 before the reset test
        add_frame(0, 16'h7000, 16'd1, 2, 2'd0, -1, 0);
        exp_frame(16'h7000, 16'd1, 2);
        drive();
        run_until("pre_rst", 100);

        // reset after two of five beats
        out_cnt = 0;
        add_frame(3, 16'h8300, 16'd1, 5, 2'd0, -1, 0);
        exp_frame(16'h8300, 16'd1, 5);
        drive();
        n = 0;
        while (out_cnt < 2 && n < 50) begin
            step();
            n++;
        end
        chk("rst_two_beats", 32'(out_cnt), 32'd2);
        mon_en = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) src_q[i].delete();
        drive();
        step();
        chk_reset_state("midrst");
        reset = 1'b0;
        exp_q.delete();
        held_v = 1'b0;
        mon_en = 1'b1;
        add_frame(0, 16'h9000, 16'd1, 2, 2'd0, -1, 0);
        add_frame(1, 16'h9100, 16'd1, 2, 2'd0, -1, 0);
        exp_frame(16'h9000, 16'd1, 2);
        exp_frame(16'h9100, 16'd1, 2);
        drive();
        wait_busy("post_rst");
        chk("post_rst_grant", 32'(grant_idx), 32'd0);
        run_until("post_rst", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
